// File: rtl/cdb_arbiter_pkg.sv
// Shared result-bus types and ROB tag helpers for the CDB arbiter and ROB flush logic.
package cdb_arbiter_pkg;

  localparam int CDB_TAG_W  = 4;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic                  rdy;
    logic [CDB_DATA_W-1:0] data;
  } sal_t;

  typedef struct packed {
    logic valid;
    sal_t res;
  } cdb_port_t;

  // Modular distance (a - b) mod size between two ROB tags.
  function automatic logic [CDB_TAG_W-1:0] rob_dist(input logic [CDB_TAG_W-1:0] a,
                                                    input logic [CDB_TAG_W-1:0] b,
                                                    input int size);
    int d;
    d = (int'(a) - int'(b)) % size;
    if (d < 0) d = d + size;
    return CDB_TAG_W'(d);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational circular priority picker: first set request at or after start, wrapping.
module rr_picker #(
  parameter int N  = 17,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(start) + i) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: kills flushed results, grants up to NUM_PORTS per cycle, registers the bus.
// Optional macro CDB_AGE_PRIORITY_EN selects oldest-tag-first ordering instead of round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 17,
  parameter int NUM_PORTS = 2,
  parameter int ROB_SIZE  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  sal_t [NUM_REQ-1:0]           req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         flush_valid,
  input  logic [CDB_TAG_W-1:0]         flush_tag,
  input  logic [CDB_TAG_W-1:0]         rear_tag,
  input  logic [CDB_TAG_W-1:0]         front_tag,
  output logic [NUM_PORTS-1:0]         cdb_valid,
  output sal_t [NUM_PORTS-1:0]         cdb_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        rr_next;
  logic                 flush_noop;
  logic [NUM_REQ-1:0]   killed;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant_all;
  logic [NUM_PORTS-1:0] pick_found;
  logic [IW-1:0]        pick_idx [NUM_PORTS];
  cdb_port_t            slot_next [NUM_PORTS];
  logic                 unused_bits;

  // A flush tag just past the rear means the squashed range is empty.
  assign flush_noop = (flush_tag == CDB_TAG_W'((int'(rear_tag) + 1) % ROB_SIZE));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gen_kill
    assign killed[gi] = flush_valid && !flush_noop &&
                        (rob_dist(req_data[gi].tag, flush_tag, ROB_SIZE) <=
                         rob_dist(rear_tag, flush_tag, ROB_SIZE));
  end

  assign eligible = req_valid & ~killed;

  // Each stage picks from what earlier stages left over, so slots fill in grant order.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : gen_port
    logic [NUM_REQ-1:0] stage_req;
    logic [NUM_REQ-1:0] stage_grant;
    logic [IW-1:0]      stage_idx;
    logic               stage_found;

    if (gi == 0) begin : g_first
      assign stage_req = eligible;
    end else begin : g_next
      assign stage_req = gen_port[gi-1].stage_req & ~gen_port[gi-1].stage_grant;
    end

`ifdef CDB_AGE_PRIORITY_EN
    logic [CDB_TAG_W-1:0] best_age;
    always_comb begin
      stage_found = 1'b0;
      stage_idx   = '0;
      best_age    = '0;
      stage_grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stage_req[i] &&
            (!stage_found || rob_dist(req_data[i].tag, front_tag, ROB_SIZE) < best_age)) begin
          stage_found = 1'b1;
          stage_idx   = IW'(i);
          best_age    = rob_dist(req_data[i].tag, front_tag, ROB_SIZE);
        end
      end
      if (stage_found) stage_grant[stage_idx] = 1'b1;
    end
`else
    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req   (stage_req),
      .start (rr_ptr),
      .grant (stage_grant),
      .idx   (stage_idx),
      .found (stage_found)
    );
`endif

    assign pick_found[gi] = stage_found;
    assign pick_idx[gi]   = stage_idx;
  end

  assign grant_all = eligible & ~(gen_port[NUM_PORTS-1].stage_req &
                                  ~gen_port[NUM_PORTS-1].stage_grant);

  // Killed results are consumed without a slot so their RS entries free up.
  assign req_ready = rst ? (grant_all | (req_valid & killed)) : '0;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      slot_next[p] = '0;
      if (pick_found[p]) begin
        slot_next[p].valid    = 1'b1;
        slot_next[p].res.tag  = req_data[pick_idx[p]].tag;
        slot_next[p].res.rdy  = 1'b1;
        slot_next[p].res.data = req_data[pick_idx[p]].data;
      end
    end
  end

`ifdef CDB_AGE_PRIORITY_EN
  assign rr_next     = '0;
  assign unused_bits = ^{rr_ptr, req_data};
`else
  always_comb begin
    rr_next = rr_ptr;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pick_found[p]) rr_next = IW'((int'(pick_idx[p]) + 1) % NUM_REQ);
    end
  end
  assign unused_bits = ^{front_tag, req_data};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid <= '0;
      cdb_o     <= '0;
      rr_ptr    <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        cdb_valid[p] <= slot_next[p].valid;
        cdb_o[p]     <= slot_next[p].res;
      end
      rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default round-robin build, or CDB_AGE_PRIORITY_EN).
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic             clk;
  logic             rst;
  logic [16:0]      req_valid;
  sal_t [16:0]      req_data;
  logic [16:0]      req_ready;
  logic             flush_valid;
  logic [3:0]       flush_tag;
  logic [3:0]       rear_tag;
  logic [3:0]       front_tag;
  logic [1:0]       cdb_valid;
  sal_t [1:0]       cdb_o;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.NUM_REQ(17), .NUM_PORTS(2), .ROB_SIZE(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .flush_valid (flush_valid),
    .flush_tag   (flush_tag),
    .rear_tag    (rear_tag),
    .front_tag   (front_tag),
    .cdb_valid   (cdb_valid),
    .cdb_o       (cdb_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sal_t exp_slot(input int i);
    sal_t s;
    s     = req_data[i];
    s.rdy = 1'b1;
    return s;
  endfunction

  task automatic do_reset();
    rst         = 1'b0;
    req_valid   = '0;
    flush_valid = 1'b0;
    flush_tag   = '0;
    rear_tag    = '0;
    front_tag   = '0;
    for (int i = 0; i < 17; i++) begin
      req_data[i].tag  = (i < 8) ? 4'(i) : 4'd7;
      req_data[i].rdy  = 1'b0;
      req_data[i].data = 32'h100 + 32'(i);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst       = 1'b0;
    req_valid = '1;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 17'd0) begin
      errors++; $display("FAIL reset_ready: got %h expected %h", req_ready, 17'd0);
    end
    checks++;
    if (cdb_valid !== 2'b00 || cdb_o !== '0) begin
      errors++; $display("FAIL reset_cdb: got valid=%b bus=%h expected valid=00 bus=0", cdb_valid, cdb_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 17'h00003) begin
      errors++; $display("FAIL reset_first_grant: got %h expected %h", req_ready, 17'h00003);
    end
    @(negedge clk);
    checks++;
    if (cdb_valid !== 2'b11 || cdb_o[0] !== exp_slot(0) || cdb_o[1] !== exp_slot(1)) begin
      errors++; $display("FAIL reset_first_cdb: got valid=%b s0=%h s1=%h expected valid=11 s0=%h s1=%h",
                         cdb_valid, cdb_o[0], cdb_o[1], exp_slot(0), exp_slot(1));
    end
    $display("[reset] valid=%b s0=%h s1=%h", cdb_valid, cdb_o[0], cdb_o[1]);
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    int ga[3] = '{3, 9, 5};
    int gb[3] = '{5, 3, 9};
    logic [16:0] exp_rdy;
    do_reset();
    req_valid = (17'd1 << 3) | (17'd1 << 5) | (17'd1 << 9);
    for (int c = 0; c < 3; c++) begin
      exp_rdy = (17'd1 << ga[c]) | (17'd1 << gb[c]);
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_ready_c%0d: got %h expected %h", c, req_ready, exp_rdy);
      end
      @(negedge clk);
      checks++;
      if (cdb_valid !== 2'b11 || cdb_o[0] !== exp_slot(ga[c]) || cdb_o[1] !== exp_slot(gb[c])) begin
        errors++; $display("FAIL rr_cdb_c%0d: got valid=%b s0=%h s1=%h expected valid=11 s0=%h s1=%h",
                           c, cdb_valid, cdb_o[0], cdb_o[1], exp_slot(ga[c]), exp_slot(gb[c]));
      end
      $display("[round_robin] cycle %0d valid=%b s0=%h s1=%h", c, cdb_valid, cdb_o[0], cdb_o[1]);
    end
    req_valid = '0;
  endtask

  task automatic test_flush_kill();
    do_reset();
    front_tag = 4'd2; rear_tag = 4'd6; flush_tag = 4'd5; flush_valid = 1'b1;
    req_data[2].tag = 4'd4; req_data[3].tag = 4'd5; req_data[4].tag = 4'd6;
    req_valid = 17'h0001C;
    #1;
    checks++;
    if (req_ready !== 17'h0001C) begin
      errors++; $display("FAIL kill_ready: got %h expected %h", req_ready, 17'h0001C);
    end
    @(negedge clk);
    flush_valid = 1'b0;
    req_valid   = '0;
    checks++;
    if (cdb_valid !== 2'b01 || cdb_o[0] !== exp_slot(2) || cdb_o[1] !== '0) begin
      errors++; $display("FAIL kill_cdb: got valid=%b s0=%h s1=%h expected valid=01 s0=%h s1=0",
                         cdb_valid, cdb_o[0], cdb_o[1], exp_slot(2));
    end
    $display("[flush_kill] valid=%b s0=%h s1=%h", cdb_valid, cdb_o[0], cdb_o[1]);
    @(negedge clk);
    checks++;
    if (cdb_valid !== 2'b00 || cdb_o !== '0) begin
      errors++; $display("FAIL kill_drain: got valid=%b bus=%h expected valid=00 bus=0", cdb_valid, cdb_o);
    end
  endtask

  task automatic test_flush_nokill();
    do_reset();
    front_tag = 4'd2; rear_tag = 4'd6; flush_tag = 4'd7; flush_valid = 1'b1;
    req_data[2].tag = 4'd4; req_data[3].tag = 4'd5; req_data[4].tag = 4'd6;
    req_valid = 17'h0001C;
    #1;
    checks++;
    if (req_ready !== 17'h0000C) begin
      errors++; $display("FAIL nokill_ready: got %h expected %h", req_ready, 17'h0000C);
    end
    @(negedge clk);
    req_valid = 17'h00010;
    checks++;
    if (cdb_valid !== 2'b11 || cdb_o[0] !== exp_slot(2) || cdb_o[1] !== exp_slot(3)) begin
      errors++; $display("FAIL nokill_cdb0: got valid=%b s0=%h s1=%h expected valid=11 s0=%h s1=%h",
                         cdb_valid, cdb_o[0], cdb_o[1], exp_slot(2), exp_slot(3));
    end
    #1;
    checks++;
    if (req_ready !== 17'h00010) begin
      errors++; $display("FAIL nokill_ready2: got %h expected %h", req_ready, 17'h00010);
    end
    @(negedge clk);
    req_valid = '0;
    flush_valid = 1'b0;
    checks++;
    if (cdb_valid !== 2'b01 || cdb_o[0] !== exp_slot(4) || cdb_o[1] !== '0) begin
      errors++; $display("FAIL nokill_cdb1: got valid=%b s0=%h s1=%h expected valid=01 s0=%h s1=0",
                         cdb_valid, cdb_o[0], cdb_o[1], exp_slot(4));
    end
    $display("[flush_nokill] valid=%b s0=%h s1=%h", cdb_valid, cdb_o[0], cdb_o[1]);
  endtask

  task automatic test_wrap_kill();
    do_reset();
    front_tag = 4'd6; rear_tag = 4'd1; flush_tag = 4'd0; flush_valid = 1'b1;
    req_data[0].tag = 4'd7; req_data[1].tag = 4'd0; req_data[2].tag = 4'd1;
    req_valid = 17'h00007;
    #1;
    checks++;
    if (req_ready !== 17'h00007) begin
      errors++; $display("FAIL wrap_ready: got %h expected %h", req_ready, 17'h00007);
    end
    @(negedge clk);
    flush_valid = 1'b0;
    req_valid   = '0;
    checks++;
    if (cdb_valid !== 2'b01 || cdb_o[0] !== exp_slot(0) || cdb_o[1] !== '0) begin
      errors++; $display("FAIL wrap_cdb: got valid=%b s0=%h s1=%h expected valid=01 s0=%h s1=0",
                         cdb_valid, cdb_o[0], cdb_o[1], exp_slot(0));
    end
    $display("[wrap_kill] valid=%b s0=%h s1=%h", cdb_valid, cdb_o[0], cdb_o[1]);
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 17'd1 << 12;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== (17'd1 << 12)) begin
        errors++; $display("FAIL b2b_ready_c%0d: got %h expected %h", c, req_ready, 17'd1 << 12);
      end
      @(negedge clk);
      checks++;
      if (cdb_valid !== 2'b01 || cdb_o[0] !== exp_slot(12) || cdb_o[1] !== '0) begin
        errors++; $display("FAIL b2b_cdb_c%0d: got valid=%b s0=%h s1=%h expected valid=01 s0=%h s1=0",
                           c, cdb_valid, cdb_o[0], cdb_o[1], exp_slot(12));
      end
      $display("[back_to_back] cycle %0d valid=%b s0=%h", c, cdb_valid, cdb_o[0]);
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (cdb_valid !== 2'b00 || cdb_o !== '0) begin
      errors++; $display("FAIL b2b_clear: got valid=%b bus=%h expected valid=00 bus=0", cdb_valid, cdb_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 17'd1 << 7;
    @(negedge clk);
    checks++;
    if (cdb_valid !== 2'b01 || cdb_o[0] !== exp_slot(7)) begin
      errors++; $display("FAIL mid_pre: got valid=%b s0=%h expected valid=01 s0=%h", cdb_valid, cdb_o[0], exp_slot(7));
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (cdb_valid !== 2'b00 || cdb_o !== '0 || req_ready !== 17'd0) begin
      errors++; $display("FAIL mid_reset: got valid=%b bus=%h ready=%h expected all zero", cdb_valid, cdb_o, req_ready);
    end
    $display("[reset_mid] valid=%b ready=%h", cdb_valid, req_ready);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
  endtask

`ifdef CDB_AGE_PRIORITY_EN
  task automatic test_age_priority();
    do_reset();
    front_tag = 4'd6;
    req_data[0].tag = 4'd1; req_data[1].tag = 4'd7; req_data[2].tag = 4'd6;
    req_valid = 17'h00007;
    #1;
    checks++;
    if (req_ready !== 17'h00006) begin
      errors++; $display("FAIL age_ready0: got %h expected %h", req_ready, 17'h00006);
    end
    @(negedge clk);
    req_valid = 17'h00001;
    checks++;
    if (cdb_valid !== 2'b11 || cdb_o[0] !== exp_slot(2) || cdb_o[1] !== exp_slot(1)) begin
      errors++; $display("FAIL age_cdb0: got valid=%b s0=%h s1=%h expected valid=11 s0=%h s1=%h",
                         cdb_valid, cdb_o[0], cdb_o[1], exp_slot(2), exp_slot(1));
    end
    #1;
    checks++;
    if (req_ready !== 17'h00001) begin
      errors++; $display("FAIL age_ready1: got %h expected %h", req_ready, 17'h00001);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (cdb_valid !== 2'b01 || cdb_o[0] !== exp_slot(0)) begin
      errors++; $display("FAIL age_cdb1: got valid=%b s0=%h expected valid=01 s0=%h", cdb_valid, cdb_o[0], exp_slot(0));
    end
    $display("[age_priority] valid=%b s0=%h", cdb_valid, cdb_o[0]);
  endtask
`endif

  initial begin
    test_reset();
`ifdef CDB_AGE_PRIORITY_EN
    test_age_priority();
`else
    test_round_robin();
`endif
    test_flush_kill();
    test_flush_nokill();
    test_wrap_kill();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
